// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment driver stepped by rising edges of a
// divided scan clock. It blanks all anodes between digits to avoid ghosting
// and latches display data once per frame so a frame never tears.
module seg7_scan #(
   parameter int NUM_DIGITS   = 8,
   parameter int BLANK_CYCLES = 4,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    SCAN_CLK,
   input  logic [4*NUM_DIGITS-1:0] DATA,
   input  logic [NUM_DIGITS-1:0]   DP_EN,
   input  logic                    LZ_BLANK,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [6:0]              SEG,
   output logic                    DP,
   output logic                    FRAME
);

   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [DW-1:0] LAST_DIG   = DW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES - 1);
   localparam bit            INV        = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t                  state_q, state_d;
   logic [DW-1:0]           dig_q, dig_d;
   logic [BW-1:0]           bcnt_q, bcnt_d;
   logic                    scan_q;
   logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [NUM_DIGITS-1:0]   dpen_sh_q, dpen_sh_d;
   logic                    lz_sh_q, lz_sh_d;
   logic                    frame_pend_q, frame_pend_d;
   logic                    frame_q, frame_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic                    tick;
   logic                    advance;
   logic                    wrap;
   logic [3:0]              nib_cur;
   logic                    dp_cur;
   logic                    upper_zero;
   logic                    blank_cur;
   logic [NUM_DIGITS-1:0]   onehot;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
      endcase
   endfunction

   // Scan clock shares the CLK source, so a plain one-flop edge detect suffices.
   assign tick = SCAN_CLK & ~scan_q;

   // Select the current digit's shadow nibble/DP and decide leading-zero blanking.
   always_comb begin
      nib_cur    = 4'h0;
      dp_cur     = 1'b0;
      upper_zero = 1'b1;
      onehot     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (DW'(i) == dig_q) begin
            nib_cur   = data_sh_q[4*i +: 4];
            dp_cur    = dpen_sh_q[i];
            onehot[i] = 1'b1;
         end
         if (i >= int'(dig_q) && data_sh_q[4*i +: 4] != 4'h0)
            upper_zero = 1'b0;
      end
      blank_cur = lz_sh_q && (dig_q != '0) && upper_zero;
   end

   // Next-state: advance on an accepted tick, count out the blank gap, then show.
   always_comb begin
      state_d      = state_q;
      dig_d        = dig_q;
      bcnt_d       = bcnt_q;
      data_sh_d    = data_sh_q;
      dpen_sh_d    = dpen_sh_q;
      lz_sh_d      = lz_sh_q;
      advance      = 1'b0;
      wrap         = (dig_q == LAST_DIG);
      case (state_q)
         S_IDLE, S_SHOW: advance = tick;
         S_BLANK: begin
            // ticks arriving while blanking are intentionally discarded
            if (bcnt_q == '0) state_d = S_SHOW;
            else              bcnt_d  = bcnt_q - BW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (advance) begin
         dig_d   = wrap ? '0 : dig_q + DW'(1);
         bcnt_d  = BLANK_INIT;
         state_d = S_BLANK;
         if (wrap) begin
            data_sh_d = DATA;
            dpen_sh_d = DP_EN;
            lz_sh_d   = LZ_BLANK;
         end
      end
      frame_pend_d = advance && wrap;
      frame_d      = frame_pend_q;
   end

   // Output decode from registered state only; inactive outside SHOW.
   always_comb begin
      an_d  = {NUM_DIGITS{INV}};
      seg_d = {7{INV}};
      dp_d  = INV;
      if (state_q == S_SHOW) begin
         an_d  = onehot ^ {NUM_DIGITS{INV}};
         seg_d = (blank_cur ? 7'h00 : hex7(nib_cur)) ^ {7{INV}};
         dp_d  = dp_cur ^ INV;
      end
   end

   // All state and outputs; async reset forces outputs inactive immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         dig_q        <= LAST_DIG;
         bcnt_q       <= '0;
         scan_q       <= 1'b0;
         data_sh_q    <= '0;
         dpen_sh_q    <= '0;
         lz_sh_q      <= 1'b0;
         frame_pend_q <= 1'b0;
         frame_q      <= 1'b0;
         an_q         <= {NUM_DIGITS{INV}};
         seg_q        <= {7{INV}};
         dp_q         <= INV;
      end else begin
         state_q      <= state_d;
         dig_q        <= dig_d;
         bcnt_q       <= bcnt_d;
         scan_q       <= SCAN_CLK;
         data_sh_q    <= data_sh_d;
         dpen_sh_q    <= dpen_sh_d;
         lz_sh_q      <= lz_sh_d;
         frame_pend_q <= frame_pend_d;
         frame_q      <= frame_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign AN    = an_q;
   assign SEG   = seg_q;
   assign DP    = dp_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a cycle-level reference model predicts each digit
// display and each FRAME pulse; a monitor pops and compares them.
module tb_seg7_scan;
   localparam int N = 8;
   localparam int B = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic         SCAN_CLK;
   logic [31:0]  DATA;
   logic [7:0]   DP_EN;
   logic         LZ_BLANK;
   logic [7:0]   AN;
   logic [6:0]   SEG;
   logic         DP;
   logic         FRAME;

   seg7_scan #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .ACTIVE_LOW(1)) dut (
      .CLK(CLK), .RST(RST), .SCAN_CLK(SCAN_CLK), .DATA(DATA), .DP_EN(DP_EN),
      .LZ_BLANK(LZ_BLANK), .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      int         cyc;
   } exp_t;

   exp_t showq[$];
   int   frameq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected look of digit d for a latched frame snapshot.
   function automatic exp_t digit_view(int d, logic [31:0] data, logic [7:0] dpen,
                                       logic lz, int when);
      exp_t        e;
      logic [31:0] above;
      logic [3:0]  nib;
      above = data >> (4*d);
      nib   = above[3:0];
      e.an  = ~(8'd1 << d);
      e.seg = (lz && d > 0 && above == 0) ? 7'h7F : ~hex_tbl[nib];
      e.dp  = ~dpen[d];
      e.cyc = when;
      return e;
   endfunction

   // Reference model: accepted ticks step the digit; a tick within B edges of
   // the previous accepted one falls into the blank gap and is ignored.
   int          m_dig;
   bit          m_idle;
   bit          m_prev;
   int          m_last;
   logic [31:0] m_data;
   logic [7:0]  m_dpen;
   logic        m_lz;

   always @(posedge CLK) begin
      cyc++;
      if (RST) begin
         m_idle = 1; m_dig = N-1; m_prev = 0; m_last = -100;
         m_data = 0; m_dpen = 0; m_lz = 0;
         showq.delete(); frameq.delete();
      end else begin
         if (SCAN_CLK && !m_prev && (m_idle || cyc > m_last + B)) begin
            m_idle = 0;
            m_last = cyc;
            m_dig  = (m_dig + 1) % N;
            if (m_dig == 0) begin
               m_data = DATA; m_dpen = DP_EN; m_lz = LZ_BLANK;
               frameq.push_back(cyc + 1);
            end
            showq.push_back(digit_view(m_dig, m_data, m_dpen, m_lz, cyc + B + 1));
         end
         m_prev = SCAN_CLK;
      end
   end

   // Monitor: each newly lit anode pattern is one digit presentation.
   logic [7:0] an_prev = 8'hFF;
   always @(negedge CLK) begin
      if (!RST) begin
         if (AN != 8'hFF && AN != an_prev) begin
            if (showq.size() == 0) begin
               checks++; failures++;
               $display("FAIL show_unexpected actual_an=%h required=none cyc=%0d", AN, cyc);
            end else begin
               exp_t e;
               e = showq.pop_front();
               chk("show_an",  AN,  e.an);
               chk("show_seg", SEG, e.seg);
               chk("show_dp",  DP,  e.dp);
               chk("show_cyc", cyc, e.cyc);
            end
         end
         if (AN == 8'hFF) chk("blank_segdp", {SEG, DP}, {7'h7F, 1'b1});
         if (FRAME) begin
            if (frameq.size() == 0) begin
               checks++; failures++;
               $display("FAIL frame_unexpected actual=1 required=0 cyc=%0d", cyc);
            end else begin
               chk("frame_cyc", cyc, frameq.pop_front());
            end
         end
      end
      an_prev = AN;
   end

   task automatic scan(input int n, input int per);
      repeat (n) begin
         SCAN_CLK = 1'b1;
         repeat (per/2) @(negedge CLK);
         SCAN_CLK = 1'b0;
         repeat (per - per/2) @(negedge CLK);
      end
   endtask

   initial begin
      bit found;
      RST = 1'b1; SCAN_CLK = 1'b0; DATA = 32'h12345678; DP_EN = 8'h00; LZ_BLANK = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_an", AN, 8'hFF);
      chk("reset_seg", SEG, 7'h7F);
      chk("reset_dp", DP, 1'b1);
      chk("reset_frame", FRAME, 1'b0);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      chk("idle_an", AN, 8'hFF);

      // first tick, full frame and one wrap
      scan(9, 16);
      // no tearing: change data mid-frame
      DATA = 32'h11111111;
      scan(8, 16);
      scan(4, 16);
      DATA = 32'h22222222;
      scan(12, 16);

      // leading-zero blanking on and off
      DATA = 32'h00000A05; LZ_BLANK = 1'b1; DP_EN = 8'h80;
      scan(16, 16);
      LZ_BLANK = 1'b0;
      scan(16, 16);

      // dropped ticks: second rise lands 3 cycles after an accepted one
      repeat (4) begin
         SCAN_CLK = 1'b1; @(negedge CLK);
         SCAN_CLK = 1'b0; repeat (2) @(negedge CLK);
         SCAN_CLK = 1'b1; repeat (10) @(negedge CLK);
         SCAN_CLK = 1'b0; repeat (8) @(negedge CLK);
      end

      // held high: digit stays lit
      SCAN_CLK = 1'b1; repeat (40) @(negedge CLK);
      SCAN_CLK = 1'b0; repeat (8) @(negedge CLK);

      // randomized periods, duty, glitches and data/option changes
      for (int k = 0; k < 60; k++) begin
         int per, hi;
         per = $urandom_range(8, 24);
         hi  = $urandom_range(1, per - 1);
         if ($urandom_range(0, 2) == 0) DATA = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 3) == 0) DP_EN = 8'($urandom);
         if ($urandom_range(0, 3) == 0) LZ_BLANK = 1'($urandom);
         SCAN_CLK = 1'b1; repeat (hi) @(negedge CLK);
         SCAN_CLK = 1'b0; repeat (per - hi) @(negedge CLK);
         if ($urandom_range(0, 5) == 0) begin
            SCAN_CLK = 1'b1; @(negedge CLK);
            SCAN_CLK = 1'b0; @(negedge CLK);
         end
      end

      // reset while digit 5 is lit
      DATA = 32'h87654321;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         SCAN_CLK = 1'b1; repeat (8) @(negedge CLK);
         if (AN == 8'hDF) found = 1;
         else begin SCAN_CLK = 1'b0; repeat (8) @(negedge CLK); end
      end
      chk("reach_digit5", found, 1'b1);
      #2 RST = 1'b1;
      #1;
      chk("midrst_an", AN, 8'hFF);
      chk("midrst_seg", SEG, 7'h7F);
      chk("midrst_dp", DP, 1'b1);
      chk("midrst_frame", FRAME, 1'b0);
      repeat (3) @(negedge CLK);
      SCAN_CLK = 1'b0;
      DATA = $urandom;
      RST = 1'b0;
      scan(10, 16);

      SCAN_CLK = 1'b0;
      repeat (30) @(negedge CLK);
      chk("show_q_drained", showq.size(), 0);
      chk("frame_q_drained", frameq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
